note_lane_judge: RTL and testbench

- Receiving end of the note-generator `press` stream for one DDR arrow lane.
- Samples `press` once per scroll tick and injects a note at the top of a LED column shift register.
- Scrolls the notes toward the bottom and judges player key presses against a hit zone at the bottom of the column.
- Produces hit/miss pulses and a running score for the scoreboard/display logic.

---
 rtl/note_lane_judge.sv | 121 ++++++++++++
 tb/tb_note_lane_judge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_judge.sv
// -----------------------------------------------------------------------------
// note_lane_judge
//
// Receives the note-generator press stream for one arrow lane. A note enters
// at the top of a LED column on each scroll tick where press is high. The
// column scrolls toward the bottom, and player key presses are judged against
// a hit zone made of the bottom HIT_WIN cells.
//
// Optional feature: define NOTE_LANE_COMBO_EN to add the combo counter and
// its output port.
//
// Parameters:
//   LANE_LEN  cells in the column (bit 0 = top/entry, bit LANE_LEN-1 = bottom)
//   TICK_DIV  clock cycles per scroll step
//   HIT_WIN   bottom cells forming the hit zone (1..LANE_LEN)
//   SCORE_W   score counter width
//   COMBO_W   combo counter width (NOTE_LANE_COMBO_EN only)
//
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous active-high reset, highest priority
//   press  in   note request, sampled only on tick cycles
//   key    in   player button, active-high, already synchronous
//   lane   out  note occupancy per cell (LED drive)
//   hit    out  one-cycle pulse on a correct press
//   miss   out  one-cycle pulse on a wrong press or an escaped note
//   score  out  saturating hit count
//   combo  out  saturating consecutive-hit count (NOTE_LANE_COMBO_EN only)
// -----------------------------------------------------------------------------
module note_lane_judge #(
   parameter int LANE_LEN = 8,
   parameter int TICK_DIV = 25,
   parameter int HIT_WIN  = 2,
   parameter int SCORE_W  = 10,
   parameter int COMBO_W  = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                press,
   input  logic                key,
   output logic [LANE_LEN-1:0] lane,
   output logic                hit,
   output logic                miss,
`ifdef NOTE_LANE_COMBO_EN
   output logic [COMBO_W-1:0]  combo,
`endif
   output logic [SCORE_W-1:0]  score
);

   // At least one bit so that TICK_DIV = 1 still has a legal counter.
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0]    cnt;
   logic                key_q;
   logic                tick;
   logic                key_rise;
   logic                zone_any;
   logic [LANE_LEN-1:0] clr_mask;
   logic                judge_hit;
   logic                judge_miss;
   logic [LANE_LEN-1:0] lane_cleared;
   logic                escape;
   logic [LANE_LEN-1:0] lane_next;

   always_comb begin
      tick     = (cnt == CNT_W'(TICK_DIV - 1));
      key_rise = key & ~key_q;

      // Ascending scan: the last set bit found is the highest index, i.e. the
      // note closest to the bottom, which is the one a press should take.
      zone_any = 1'b0;
      clr_mask = '0;
      for (int i = LANE_LEN - HIT_WIN; i < LANE_LEN; i++) begin
         if (lane[i]) begin
            zone_any    = 1'b1;
            clr_mask    = '0;
            clr_mask[i] = 1'b1;
         end
      end

      judge_hit  = key_rise & zone_any;
      judge_miss = key_rise & ~zone_any;

      // Judgement acts on the pre-shift lane; the scroll then works on the
      // cleared value, so a note taken at the bottom cannot also escape.
      lane_cleared = judge_hit ? (lane & ~clr_mask) : lane;
      escape       = tick & lane_cleared[LANE_LEN-1];
      lane_next    = tick ? {lane_cleared[LANE_LEN-2:0], press} : lane_cleared;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt   <= '0;
         key_q <= 1'b0;
         lane  <= '0;
         hit   <= 1'b0;
         miss  <= 1'b0;
         score <= '0;
      end else begin
         cnt   <= tick ? '0 : cnt + 1'b1;
         key_q <= key;
         lane  <= lane_next;
         hit   <= judge_hit;
         miss  <= judge_miss | escape;
         if (judge_hit && (score != {SCORE_W{1'b1}}))
            score <= score + 1'b1;
      end
   end

`ifdef NOTE_LANE_COMBO_EN
   always_ff @(posedge Clock) begin
      if (Reset)
         combo <= '0;
      else if (judge_miss | escape)
         combo <= '0;
      else if (judge_hit && (combo != {COMBO_W{1'b1}}))
         combo <= combo + 1'b1;
   end
`endif

endmodule

// File: tb/tb_note_lane_judge.sv
// -----------------------------------------------------------------------------
// tb_note_lane_judge
//
// Directed bench for note_lane_judge with LANE_LEN=8, TICK_DIV=4, HIT_WIN=2,
// SCORE_W=10. The bench keeps its own tick phase (reset to 0, a tick edge
// whenever the phase is 3) so that key presses can be placed on or off tick
// cycles. Inputs change 1 time unit after the rising edge; outputs are sampled
// at the same point.
// -----------------------------------------------------------------------------
module tb_note_lane_judge;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       press = 1'b0;
   logic       key   = 1'b0;
   logic [7:0] lane;
   logic       hit;
   logic       miss;
   logic [9:0] score;
`ifdef NOTE_LANE_COMBO_EN
   logic [7:0] combo;
`endif

   int checks = 0;
   int errors = 0;
   int phase  = 0;
   int hcnt;
   int mcnt;

   note_lane_judge #(
      .LANE_LEN(8),
      .TICK_DIV(4),
      .HIT_WIN (2),
      .SCORE_W (10),
      .COMBO_W (8)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .press(press),
      .key  (key),
      .lane (lane),
      .hit  (hit),
      .miss (miss),
`ifdef NOTE_LANE_COMBO_EN
      .combo(combo),
`endif
      .score(score)
   );

   always #5 Clock = ~Clock;

   // One clock edge; tracks where the tick counter now sits.
   task automatic step();
      @(posedge Clock);
      #1;
      if (Reset) phase = 0;
      else       phase = (phase + 1) % 4;
   endtask

   // Advance to the next tick edge with press = p during the whole approach.
   task automatic tick_once(input logic p);
      press = p;
      while (phase != 3) step();
      step();
      press = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---------------- reset ----------------
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("rst_lane", 32'(lane), 32'h00);
      check("rst_hit", 32'(hit), 32'h0);
      check("rst_miss", 32'(miss), 32'h0);
      check("rst_score", 32'(score), 32'h0);
`ifdef NOTE_LANE_COMBO_EN
      check("rst_combo", 32'(combo), 32'h0);
`endif

      // ---------------- note escape ----------------
      // press high on a non-tick edge must be ignored
      press = 1'b1;
      step();
      check("press_ignored", 32'(lane), 32'h00);
      tick_once(1'b1);
      check("esc_tick1", 32'(lane), 32'h01);
      for (int i = 0; i < 7; i++) tick_once(1'b0);
      check("esc_tick8", 32'(lane), 32'h80);
      check("esc_tick8_miss", 32'(miss), 32'h0);
      tick_once(1'b0);
      check("esc_tick9_lane", 32'(lane), 32'h00);
      check("esc_tick9_miss", 32'(miss), 32'h1);
      step();
      check("esc_miss_drop", 32'(miss), 32'h0);
      check("esc_score", 32'(score), 32'h0);

      // ---------------- correct press (non-tick) ----------------
      tick_once(1'b1);
      for (int i = 0; i < 6; i++) tick_once(1'b0);
      check("cp_setup", 32'(lane), 32'h40);
      key = 1'b1;                       // phase 0: not a tick edge
      step();
      check("cp_lane", 32'(lane), 32'h00);
      check("cp_hit", 32'(hit), 32'h1);
      check("cp_miss", 32'(miss), 32'h0);
      check("cp_score", 32'(score), 32'h1);
`ifdef NOTE_LANE_COMBO_EN
      check("cp_combo", 32'(combo), 32'h1);
`endif
      key = 1'b0;
      step();
      check("cp_hit_drop", 32'(hit), 32'h0);

      // ---------------- wrong press ----------------
      // presses 1,1,0,0 (oldest first) leave bits 3 and 2 set
      tick_once(1'b1);
      tick_once(1'b1);
      tick_once(1'b0);
      tick_once(1'b0);
      check("wp_setup", 32'(lane), 32'h0C);
      key = 1'b1;
      step();
      check("wp_miss", 32'(miss), 32'h1);
      check("wp_hit", 32'(hit), 32'h0);
      check("wp_lane", 32'(lane), 32'h0C);
      check("wp_score", 32'(score), 32'h1);
`ifdef NOTE_LANE_COMBO_EN
      check("wp_combo", 32'(combo), 32'h0);
`endif
      key = 1'b0;
      step();
      check("wp_miss_drop", 32'(miss), 32'h0);

      // ---------------- held key ----------------
      for (int i = 0; i < 4; i++) tick_once(1'b0);
      check("hk_setup", 32'(lane), 32'hC0);
      key  = 1'b1;
      hcnt = 0;
      mcnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         hcnt += int'(hit);
         mcnt += int'(miss);
         if (i == 0) check("hk_first_lane", 32'(lane), 32'h40);
      end
      check("hk_hits", 32'(hcnt), 32'd1);
      check("hk_misses", 32'(mcnt), 32'd1);
      check("hk_lane", 32'(lane), 32'h00);
      check("hk_score", 32'(score), 32'h2);
      key = 1'b0;
      step();

      // ---------------- coincident key and tick ----------------
      tick_once(1'b1);
      for (int i = 0; i < 7; i++) tick_once(1'b0);
      check("co_setup", 32'(lane), 32'h80);
      while (phase != 3) step();
      key = 1'b1;                       // rises on the tick edge
      step();
      check("co_lane", 32'(lane), 32'h00);
      check("co_hit", 32'(hit), 32'h1);
      check("co_miss", 32'(miss), 32'h0);
      check("co_score", 32'(score), 32'h3);
`ifdef NOTE_LANE_COMBO_EN
      check("co_combo", 32'(combo), 32'h1);
`endif
      key = 1'b0;
      step();
      check("co_hit_drop", 32'(hit), 32'h0);

      // ---------------- full lane, then reset mid-play ----------------
      for (int i = 0; i < 8; i++) tick_once(1'b1);
      check("full_lane", 32'(lane), 32'hFF);
      check("full_no_miss", 32'(miss), 32'h0);
      tick_once(1'b1);
      check("full_scroll_lane", 32'(lane), 32'hFF);
      check("full_scroll_miss", 32'(miss), 32'h1);
      // reset coincides with a key rise; reset must win
      Reset = 1'b1;
      key   = 1'b1;
      step();
      Reset = 1'b0;
      key   = 1'b0;
      check("rm_lane", 32'(lane), 32'h00);
      check("rm_score", 32'(score), 32'h0);
      check("rm_hit", 32'(hit), 32'h0);
      check("rm_miss", 32'(miss), 32'h0);
`ifdef NOTE_LANE_COMBO_EN
      check("rm_combo", 32'(combo), 32'h0);
`endif
      step();
      check("rm_after_miss", 32'(miss), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
